key_debounce_led: RTL and testbench
===================================

// Module: key_debounce_led
// PURPOSE
//  Multi-channel push-button front end for the board. Synchronises N active-low keys to clk,
//  debounces each independently, emits one-cycle press/release strobes, and drives one LED
//  per key in FOLLOW (lit while held) or TOGGLE (flip per press) mode. Sits between board
//  key pins and LED pins/user logic; replaces the bare two-register key->LED path.
// PARAMETERS
//  NUM_KEYS     4           number of key/LED channels (>=1)
//  CLK_HZ       50_000_000  clk frequency in Hz
//  DEBOUNCE_MS  20          required stable time in ms
//  LED_MODE     0           0 = FOLLOW, 1 = TOGGLE
// PORTS
//  clk        in   1         system clock, 50 MHz on board
//  rst        in   1         synchronous, active-high reset
//  key        in   NUM_KEYS  raw key pins, active-low (0 = pressed), asynchronous
//  key_state  out  NUM_KEYS  debounced level, 1 = pressed
//  key_press  out  NUM_KEYS  1-cycle strobe on debounced press
//  key_rel    out  NUM_KEYS  1-cycle strobe on debounced release
//  led        out  NUM_KEYS  LED drive, 1 = lit
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-high on rst; it has priority over all updates.
//  - Reset values: sync regs 0, counters 0, key_state 0, key_press 0, key_rel 0, led 0.
//  - Sync: s1 <= ~key; s2 <= s1, per bit. Only s2 is used downstream.
//  - DB_CYCLES = (CLK_HZ/1000)*DEBOUNCE_MS. Must be >=1; elaboration error otherwise.
//    Counter width = clog2(DB_CYCLES+1).
//  - Per channel, each cycle:
//    - s2 == key_state: cnt <= 0.
//    - Else, cnt < DB_CYCLES-1: cnt <= cnt+1.
//    - Else: key_state <= s2 and cnt <= 0.
//    - key_press <= (update to 1); key_rel <= (update to 0). Both are 0 in all other cycles.
//  - Latency: key edge settled before edge E0 -> key_state, strobe and led change at edge
//    E0+DB_CYCLES+1. Two cycles of sync, then DB_CYCLES consecutive differing samples.
//  - Glitch: any sample with s2 == key_state clears cnt. Bounce shorter than DB_CYCLES
//    never changes key_state and produces no strobe.
//  - FOLLOW: led == key_state. TOGGLE: led[i] <= ~led[i] in the cycle key_press[i] fires.
//  - Channels are fully independent; simultaneous events on several keys all take effect
//    in the same cycle.
//  - Counter cannot wrap: it saturates at DB_CYCLES-1 and then resets.
//  - Reset mid-count discards progress. After reset, a key still held re-qualifies from
//    scratch: full latency, one press strobe; TOGGLE led goes 0 -> 1.
//  - All outputs are registered. No combinational path from key to any output.
// STRUCTURE
//  - Shared package/include key_pkg: clog2 function, LED_MODE_FOLLOW=0 / LED_MODE_TOGGLE=1
//    constants, key-active-low constant.
//  - Sub-module key_debounce_ch: one channel (sync, counter, state, strobes). Parameter
//    DB_CYCLES.
//  - Top instantiates NUM_KEYS channels in a generate loop and holds the LED mode logic.
// TESTING (bench params: CLK_HZ=1000, DEBOUNCE_MS=4 -> DB_CYCLES=4; NUM_KEYS=4)
//  1. Reset: rst=1 for 3 cycles with key=4'b1111 -> all outputs 0; after release, outputs
//     stay 0 for 20 cycles.
//  2. Clean press: key[0]=0 before edge E0 -> key_state[0]=1 and key_press[0]=1 at E0+5.
//     key_press[0]=0 at E0+6. led[0]=1 in FOLLOW.
//  3. Bounce: key[1] low 3 cycles, high 1, low 3, then high -> key_state[1] stays 0;
//     no strobe.
//  4. Release: after test 2, key[0]=1 before edge R0 -> key_state[0]=0 and key_rel[0]=1
//     at R0+5. FOLLOW led[0]=0.
//  5. TOGGLE with all keys: press/release keys 0 and 3 together twice -> key_press=4'b1001
//     on the same cycle each time. led goes 4'b1001 then 4'b0000.
//  6. Reset mid-count: key[2] low, assert rst at cycle 3 of qualification. Hold key low ->
//     key_state[2] rises exactly 5 cycles after the first post-reset edge, one press strobe.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and helpers for the key debounce / LED front end.
package key_pkg;

  localparam int LED_MODE_FOLLOW = 0;
  localparam int LED_MODE_TOGGLE = 1;

  // Board keys pull the pin low when pressed.
  localparam logic KEY_ACTIVE_LEVEL = 1'b0;

  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          w;
    w = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        w++;
        v = v >> 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, stability counter, debounced level and strobes.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic rel_o,
  output logic press_nxt_o,
  output logic rel_nxt_o
);

  localparam int CNT_W = clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 1) begin : g_bad_db
    $error("key_debounce_ch: DB_CYCLES must be at least 1");
  end

  logic             s1_q, s2_q;
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the current level restarts qualification from zero.
  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s2_q != state_q) begin
      if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        state_d = s2_q;
        press_d = s2_q;
        rel_d   = ~s2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= (key_i == KEY_ACTIVE_LEVEL);
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign state_o     = state_q;
  assign press_o     = press_q;
  assign rel_o       = rel_q;
  // Exposed so the LED register can change on the same edge as the strobe.
  assign press_nxt_o = press_d;
  assign rel_nxt_o   = rel_d;

endmodule

// File: rtl/key_debounce_led.sv
// Multi-key front end: per-key debounce channels plus FOLLOW/TOGGLE LED drive.
module key_debounce_led
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LED_MODE    = LED_MODE_FOLLOW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_rel,
  output logic [NUM_KEYS-1:0] led
);

  localparam int DB_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  if (NUM_KEYS < 1) begin : g_bad_keys
    $error("key_debounce_led: NUM_KEYS must be at least 1");
  end

  logic [NUM_KEYS-1:0] press_nxt;
  logic [NUM_KEYS-1:0] rel_nxt;
  logic [NUM_KEYS-1:0] led_q, led_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_i      (key[i]),
      .state_o    (key_state[i]),
      .press_o    (key_press[i]),
      .rel_o      (key_rel[i]),
      .press_nxt_o(press_nxt[i]),
      .rel_nxt_o  (rel_nxt[i])
    );
  end

  // FOLLOW rebuilds the debounced level from the strobes, so it always equals key_state.
  always_comb begin
    led_d = led_q;
    if (LED_MODE == LED_MODE_TOGGLE) begin
      led_d = led_q ^ press_nxt;
    end else begin
      led_d = (led_q & ~rel_nxt) | press_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_key_debounce_led.sv
// Scoreboard bench: sliding-window reference model feeds a queue checked by a negedge monitor.
module tb_key_debounce_led;

  localparam int NK = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key = '1;

  logic [NK-1:0] ksF, kpF, krF, ledF;
  logic [NK-1:0] ksT, kpT, krT, ledT;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  key_debounce_led #(.NUM_KEYS(NK), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LED_MODE(0)) dutF (
    .clk(clk), .rst(rst), .key(key),
    .key_state(ksF), .key_press(kpF), .key_rel(krF), .led(ledF)
  );

  key_debounce_led #(.NUM_KEYS(NK), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LED_MODE(1)) dutT (
    .clk(clk), .rst(rst), .key(key),
    .key_state(ksT), .key_press(kpT), .key_rel(krT), .led(ledT)
  );

  typedef struct packed {
    logic [NK-1:0] st;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] ledT;
  } exp_t;

  exp_t          expQ[$];
  logic [NK-1:0] hist[$];
  logic [NK-1:0] mState = '0;
  logic [NK-1:0] mLedT  = '0;

  // A level flips once the last DB synchronised samples (two edges old) all disagree with it.
  always @(posedge clk) begin
    exp_t          e;
    logic [NK-1:0] prev;
    logic          allDiff;
    e = '0;
    if (rst) begin
      hist.delete();
      for (int j = 0; j < DB + 2; j++) hist.push_back('0);
      mState = '0;
      mLedT  = '0;
    end else begin
      hist.push_back(~key);
      void'(hist.pop_front());
      prev = mState;
      for (int k = 0; k < NK; k++) begin
        allDiff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          if (hist[j][k] == prev[k]) allDiff = 1'b0;
        end
        if (allDiff) mState[k] = ~prev[k];
      end
      e.st   = mState;
      e.pr   = mState & ~prev;
      e.rl   = prev & ~mState;
      mLedT  = mLedT ^ e.pr;
      e.ledT = mLedT;
    end
    expQ.push_back(e);
  end

  task automatic checkOutput(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_empty at %0t: got 0 entries expected at least 1", $time);
    end else begin
      e = expQ.pop_front();
      checkOutput("key_state_follow", ksF, e.st);
      checkOutput("key_press_follow", kpF, e.pr);
      checkOutput("key_rel_follow", krF, e.rl);
      checkOutput("led_follow", ledF, e.st);
      checkOutput("key_state_toggle", ksT, e.st);
      checkOutput("key_press_toggle", kpT, e.pr);
      checkOutput("key_rel_toggle", krT, e.rl);
      checkOutput("led_toggle", ledT, e.ledT);
    end
  end

  task automatic applyStimulus(input logic [NK-1:0] k, input logic r, input int cycles);
    @(negedge clk);
    #2;
    key = k;
    rst = r;
    repeat (cycles) @(posedge clk);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(4'hF, 1'b1, 3);
    applyStimulus(4'hF, 1'b0, 20);

    applyStimulus(4'hE, 1'b0, 10);
    applyStimulus(4'hC, 1'b0, 3);
    applyStimulus(4'hE, 1'b0, 1);
    applyStimulus(4'hC, 1'b0, 3);
    applyStimulus(4'hE, 1'b0, 10);

    applyStimulus(4'hF, 1'b0, 10);

    applyStimulus(4'h6, 1'b0, 8);
    applyStimulus(4'hF, 1'b0, 8);
    applyStimulus(4'h6, 1'b0, 8);
    applyStimulus(4'hF, 1'b0, 8);

    applyStimulus(4'hB, 1'b0, 3);
    applyStimulus(4'hB, 1'b1, 1);
    applyStimulus(4'hB, 1'b0, 10);
    applyStimulus(4'hF, 1'b0, 10);

    // Hold lengths straddle DB so both bounces and qualified edges occur.
    repeat (200) begin
      applyStimulus(NK'($urandom), ($urandom_range(0, 40) == 0), $urandom_range(1, 8));
    end

    applyStimulus(4'hF, 1'b0, 12);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
